// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues one 64-bit fetch at a time to instruction
// memory and presents the returned instruction pair, with flush/stall handling.
module inst_fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pcn,
  input  logic        flush,
  input  logic        stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic [31:0] if_inst_1,
  output logic [31:0] if_inst_2,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        delay_hard,
  output logic        IADEE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       drop_pend;
  logic       accept;
  logic       aligned;

  assign accept     = pcn & ~stall & ~flush;
  assign aligned    = (pc[1:0] == 2'b00);
  assign inst_req   = (state == S_REQ);
  assign delay_hard = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && aligned) state_nxt = S_REQ;
      // A flush while the address is pending cannot cancel the request, so the beat must be dropped later
      S_REQ:  if (inst_addr_ok) state_nxt = (drop_pend || flush) ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (inst_data_ok)  state_nxt = S_IDLE;
        else if (flush)    state_nxt = S_DROP;
      end
      S_DROP: if (inst_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drop_pend <= 1'b0;
      inst_addr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ) drop_pend <= inst_addr_ok ? 1'b0 : (drop_pend | flush);
      else                drop_pend <= 1'b0;
      if (state == S_IDLE && accept && aligned) inst_addr <= pc;
    end
  end

  // Output pair register; a data beat fills it even under stall because the slot is empty while fetching
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_inst_1 <= 32'h0;
      if_inst_2 <= 32'h0;
      if_pc     <= 32'h0;
      if_valid  <= 1'b0;
      IADEE     <= 1'b0;
    end else if (flush) begin
      if_inst_1 <= 32'h0;
      if_inst_2 <= 32'h0;
      if_pc     <= 32'h0;
      if_valid  <= 1'b0;
      IADEE     <= 1'b0;
    end else if (state == S_WAIT && inst_data_ok) begin
      if_inst_1 <= inst_rdata[31:0];
      if_inst_2 <= inst_rdata[63:32];
      if_pc     <= inst_addr;
      if_valid  <= 1'b1;
      IADEE     <= 1'b0;
    end else if (state == S_IDLE && !stall) begin
      if (pcn && !aligned) begin
        if_inst_1 <= 32'h0;
        if_inst_2 <= 32'h0;
        if_pc     <= pc;
        if_valid  <= 1'b1;
        IADEE     <= 1'b1;
      end else begin
        if_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_inst_fetch_buf;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pcn;
  logic        flush;
  logic        stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic [31:0] if_inst_1;
  logic [31:0] if_inst_2;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        delay_hard;
  logic        IADEE;

  int checks = 0;
  int errors = 0;

  inst_fetch_buf dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .pcn          (pcn),
    .flush        (flush),
    .stall        (stall),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_inst_1    (if_inst_1),
    .if_inst_2    (if_inst_2),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .delay_hard   (delay_hard),
    .IADEE        (IADEE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic [31:0] pc;
    logic        pcn, flush, stall, aok, dok;
    logic [63:0] rdata;
    logic        e_req, e_dh;
    logic [31:0] e_addr;
    logic        e_valid, e_iadee;
    logic [31:0] e_pc, e_i1, e_i2;
  } vec_t;

  localparam logic [63:0] R    = 64'h24020001_3c1dbfc0;
  localparam logic [63:0] R2   = 64'h11111111_22222222;
  localparam logic [31:0] BFC0 = 32'hbfc00000;
  localparam logic [31:0] A100 = 32'hbfc00100;
  localparam logic [31:0] A380 = 32'hbfc00380;
  localparam logic [31:0] A400 = 32'hbfc00400;
  localparam logic [31:0] I1   = 32'h3c1dbfc0;
  localparam logic [31:0] I2   = 32'h24020001;
  localparam logic [31:0] Z    = 32'h0;

  function automatic vec_t mk(input logic rn, input logic [31:0] p, input logic n, input logic f,
                              input logic s, input logic a, input logic d, input logic [63:0] rd,
                              input logic er, input logic edh, input logic [31:0] ea,
                              input logic ev, input logic ei, input logic [31:0] ep,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.rn = rn; v.pc = p; v.pcn = n; v.flush = f; v.stall = s; v.aok = a; v.dok = d; v.rdata = rd;
    v.e_req = er; v.e_dh = edh; v.e_addr = ea; v.e_valid = ev; v.e_iadee = ei;
    v.e_pc = ep; v.e_i1 = e1; v.e_i2 = e2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pc = 32'h0; pcn = 1'b0; flush = 1'b0; stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 64'h0;
  endtask

  task automatic chk_all(input string tag, input logic er, input logic edh, input logic [31:0] ea,
                         input logic ev, input logic ei, input logic [31:0] ep,
                         input logic [31:0] e1, input logic [31:0] e2);
    chk({tag, "_req"},   64'(inst_req),   64'(er));
    chk({tag, "_dh"},    64'(delay_hard), 64'(edh));
    chk({tag, "_addr"},  64'(inst_addr),  64'(ea));
    chk({tag, "_valid"}, 64'(if_valid),   64'(ev));
    chk({tag, "_iadee"}, 64'(IADEE),      64'(ei));
    chk({tag, "_pc"},    64'(if_pc),      64'(ep));
    chk({tag, "_i1"},    64'(if_inst_1),  64'(e1));
    chk({tag, "_i2"},    64'(if_inst_2),  64'(e2));
  endtask

  // Reference model: one fetch transaction plus the output pair slot
  bit          m_busy, m_taken, m_doomed;
  logic [31:0] m_addr, m_pc, m_i1, m_i2;
  bit          m_v, m_iadee;

  task automatic model_reset;
    m_busy = 0; m_taken = 0; m_doomed = 0;
    m_addr = 0; m_pc = 0; m_i1 = 0; m_i2 = 0; m_v = 0; m_iadee = 0;
  endtask

  task automatic model_edge;
    bit misal;
    misal = (pc[1:0] != 2'b00);
    if (flush) begin
      m_v = 0; m_iadee = 0; m_pc = 0; m_i1 = 0; m_i2 = 0;
    end else if (m_busy && m_taken && !m_doomed && inst_data_ok) begin
      m_v = 1; m_iadee = 0; m_pc = m_addr; m_i1 = inst_rdata[31:0]; m_i2 = inst_rdata[63:32];
    end else if (!m_busy && !stall) begin
      if (pcn && misal) begin
        m_v = 1; m_iadee = 1; m_pc = pc; m_i1 = 0; m_i2 = 0;
      end else begin
        m_v = 0;
      end
    end
    if (!m_busy) begin
      if (pcn && !stall && !flush && !misal) begin
        m_busy = 1; m_taken = 0; m_doomed = 0; m_addr = pc;
      end
    end else if (!m_taken) begin
      m_doomed = m_doomed | flush;
      if (inst_addr_ok) m_taken = 1;
    end else begin
      if (inst_data_ok) m_busy = 0;
      else m_doomed = m_doomed | flush;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   mem_pending, mem_cnt, req_armed, req_cnt;
    logic [31:0] rpc;

    reset = 1'b0;
    idle_inputs();

    vecs.push_back(mk(0, Z,    0,0,0,0,0, 64'h0, 0,0,Z,    0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, BFC0, 1,0,0,0,0, 64'h0, 1,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,0,0, 64'h0, 1,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,1,0, 64'h0, 0,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,0,1, R,     0,0,BFC0, 1,0,BFC0,I1, I2));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, A100, 1,0,1,0,0, 64'h0, 0,0,BFC0, 1,0,BFC0,I1, I2));
    vecs.push_back(mk(1, A100, 1,0,0,0,0, 64'h0, 1,1,A100, 0,0,BFC0,I1, I2));
    vecs.push_back(mk(1, Z,    0,0,0,1,0, 64'h0, 0,1,A100, 0,0,BFC0,I1, I2));
    vecs.push_back(mk(1, Z,    0,1,0,0,0, 64'h0, 0,1,A100, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,0,1, R,     0,0,A100, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, A380, 1,0,0,0,0, 64'h0, 1,1,A380, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,1,0, 64'h0, 0,1,A380, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,0,1, R2,    0,0,A380, 1,0,A380,32'h22222222,32'h11111111));
    vecs.push_back(mk(1, A400, 1,0,0,0,0, 64'h0, 1,1,A400, 0,0,A380,32'h22222222,32'h11111111));
    vecs.push_back(mk(1, Z,    0,0,0,1,0, 64'h0, 0,1,A400, 0,0,A380,32'h22222222,32'h11111111));
    vecs.push_back(mk(1, Z,    0,1,0,0,1, R,     0,0,A400, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, 32'hbfc00002, 1,0,0,0,0, 64'h0, 0,0,A400, 1,1,32'hbfc00002, Z, Z));
    vecs.push_back(mk(1, BFC0, 1,1,0,0,0, 64'h0, 0,0,A400, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, BFC0, 1,0,0,0,0, 64'h0, 1,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,1,0,0,0, 64'h0, 1,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,1,0, 64'h0, 0,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,0,1, R,     0,0,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, BFC0, 1,0,0,0,0, 64'h0, 1,1,BFC0, 0,0,Z,   Z,  Z));
    vecs.push_back(mk(0, Z,    0,0,0,0,0, 64'h0, 0,0,Z,    0,0,Z,   Z,  Z));
    vecs.push_back(mk(1, Z,    0,0,0,0,0, 64'h0, 0,0,Z,    0,0,Z,   Z,  Z));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rn; pc = vecs[i].pc; pcn = vecs[i].pcn; flush = vecs[i].flush;
      stall = vecs[i].stall; inst_addr_ok = vecs[i].aok; inst_data_ok = vecs[i].dok;
      inst_rdata = vecs[i].rdata;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_dh, vecs[i].e_addr,
              vecs[i].e_valid, vecs[i].e_iadee, vecs[i].e_pc, vecs[i].e_i1, vecs[i].e_i2);
    end

    // Slow memory: address accepted only after three waiting cycles
    idle_inputs();
    pc = 32'hbfc00040; pcn = 1'b1;
    step();
    chk_all("slow_issue", 1, 1, 32'hbfc00040, 0, 0, Z, Z, Z);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("slow_hold%0d", k), 1, 1, 32'hbfc00040, 0, 0, Z, Z, Z);
    end
    inst_addr_ok = 1'b1;
    step();
    idle_inputs();
    chk_all("slow_aok", 0, 1, 32'hbfc00040, 0, 0, Z, Z, Z);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_all($sformatf("slow_wait%0d", k), 0, 1, 32'hbfc00040, 0, 0, Z, Z, Z);
    end
    inst_data_ok = 1'b1; inst_rdata = 64'haaaa5555_0f0f1234;
    step();
    idle_inputs();
    chk_all("slow_data", 0, 0, 32'hbfc00040, 1, 0, 32'hbfc00040, 32'h0f0f1234, 32'haaaa5555);

    // Asynchronous reset in the middle of a request takes effect before any edge
    pc = 32'hbfc00080; pcn = 1'b1;
    step();
    idle_inputs();
    chk("areset_pre_req", 64'(inst_req), 64'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    chk_all("areset_now", 0, 0, Z, 0, 0, Z, Z, Z);
    step();
    reset = 1'b1;

    // Randomized traffic against the reference model with a reactive memory
    model_reset();
    mem_pending = 0; mem_cnt = 0; req_armed = 0; req_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle_inputs();
      if (mem_pending != 0) begin
        if (mem_cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata = {$urandom, $urandom};
          mem_pending = 0;
        end else mem_cnt--;
      end else if (inst_req) begin
        if (req_armed == 0) begin
          req_armed = 1;
          req_cnt = int'($urandom_range(0, 3));
        end
        if (req_cnt == 0) begin
          inst_addr_ok = 1'b1;
          req_armed = 0;
          mem_pending = 1;
          mem_cnt = int'($urandom_range(0, 3));
        end else req_cnt--;
      end
      rpc = $urandom & 32'hffff_fffc;
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      pc    = rpc;
      pcn   = ($urandom_range(0, 1) == 1);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      model_edge();
      step();
      chk_all($sformatf("rnd%0d", cyc), m_busy && !m_taken, m_busy, m_addr,
              m_v, m_iadee, m_pc, m_i1, m_i2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (ports clk and reset).
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- pc  in  32  fetch address from the fetch stage
- pcn  in  1  pc is new and valid this cycle
- flush  in  1  discard pending fetch and outputs (branch/jump/interrupt)
- stall  in  1  downstream soft stall; hold outputs
- inst_req  out  1  memory request
- inst_addr  out  32  memory address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  64  [31:0] word at addr, [63:32] word at addr+4
- if_inst_1  out  32  first instruction of pair
- if_inst_2  out  32  second instruction of pair
- if_pc  out  32  pc of if_inst_1
- if_valid  out  1  output pair valid
- delay_hard  out  1  fetch in flight; fetch stage holds pc
- IADEE  out  1  instruction address alignment error for if_pc

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, DROP.
REQ-004 In IDLE, pcn=1, stall=0, flush=0 and pc[1:0]=0: latch pc into inst_addr and go to REQ next edge.
REQ-005 In IDLE, pcn=1, stall=0, flush=0 and pc[1:0]!=0: issue no memory request; next edge set if_valid=1, IADEE=1, if_pc=pc, if_inst_1=if_inst_2=0; stay IDLE.
REQ-006 In REQ, inst_req SHALL be 1 and inst_addr stable until inst_addr_ok=1; then go to WAIT (no flush) or DROP (flush seen in REQ or same cycle).
REQ-007 A request SHALL never be withdrawn before inst_addr_ok, even when flush arrives.
REQ-008 In WAIT, on inst_data_ok=1 and flush=0: latch if_inst_1=rdata[31:0], if_inst_2=rdata[63:32], if_pc=inst_addr, if_valid=1, IADEE=0; go to IDLE.
REQ-009 In WAIT, flush=1 with inst_data_ok=0 SHALL go to DROP; flush=1 with inst_data_ok=1 SHALL discard the data and go to IDLE.
REQ-010 DROP SHALL ignore the next inst_data_ok beat, leave the outputs unchanged, and return to IDLE on it.
REQ-011 delay_hard SHALL be combinational: 1 when state is REQ, WAIT or DROP, else 0.
REQ-012 A pair is consumed on an edge with if_valid=1, stall=0 and delay_hard=0; if_valid then clears unless REQ-005 loads a new pair in the same edge.
REQ-013 While stall=1, if_inst_1, if_inst_2, if_pc, if_valid and IADEE SHALL hold, and pcn SHALL be ignored.
REQ-014 flush=1 in any state SHALL clear if_valid, IADEE, if_inst_1, if_inst_2 and if_pc to 0 on the next edge.
REQ-015 flush SHALL take priority over stall, and pcn is ignored in the flush cycle.
REQ-016 Minimum latency SHALL be: pcn at edge 0 -> inst_req high after edge 0; addr_ok and data_ok each one cycle later -> if_valid high after edge 3.
REQ-017 At most one request SHALL be outstanding; no new inst_req until the previous data beat has returned.

Reset
REQ-018 reset=0 SHALL immediately force state IDLE and inst_req=0, inst_addr=0, if_inst_1=0, if_inst_2=0, if_pc=0, if_valid=0, IADEE=0; delay_hard=0 follows.
REQ-019 Reset mid-transfer SHALL abandon the transaction without a DROP, and the memory model is reset together with the block.

Verification
REQ-020 Normal fetch: pc=0xbfc00000, pcn=1; addr_ok and data_ok one cycle apart, rdata=0x24020001_3c1dbfc0 -> if_inst_1=0x3c1dbfc0, if_inst_2=0x24020001, if_pc=0xbfc00000, if_valid=1 after edge 3, delay_hard=1 during REQ and WAIT.
REQ-021 Slow memory: addr_ok delayed 3 cycles -> inst_req and inst_addr stay constant throughout; delay_hard=1 until data_ok.
REQ-022 Flush in WAIT: flush=1 before data_ok -> DROP; the returned beat is discarded, if_valid=0, then a new pcn with pc=0xbfc00380 fetches normally.
REQ-023 Simultaneous data_ok and flush in WAIT -> data discarded, state IDLE, if_valid=0 next edge.
REQ-024 Misaligned pc=0xbfc00002 -> no inst_req; IADEE=1, if_valid=1, if_pc=0xbfc00002, instruction words 0.
REQ-025 Stall hold: a valid pair with stall=1 for 4 cycles and pcn=1 -> outputs unchanged, no inst_req; stall=0 -> pair consumed and next fetch starts.
